// File: rtl/truth_sweep_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// truth_sweep_gen: drives all 2^N_IN patterns, samples dut_out, MISR signature.
// Optional golden compare: define TRUTH_SWEEP_CHECK_EN.     Rev 1.0
// ---------------------------------------------------------------------------
module truth_sweep_gen #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2,
  parameter int HOLD  = 5
`ifdef TRUTH_SWEEP_CHECK_EN
  ,
  parameter logic [N_OUT*(2**N_IN)-1:0] EXPECTED = '0
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_OUT-1:0] dut_out,
  output logic [N_IN-1:0]  pattern,
  output logic             busy,
  output logic             sample_valid,
  output logic             done,
  output logic [15:0]      signature
`ifdef TRUTH_SWEEP_CHECK_EN
  ,
  output logic [N_IN:0]    err_cnt,
  output logic [N_IN-1:0]  first_fail,
  output logic             fail
`endif
);

  localparam int              HCW       = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD - 1);
  localparam logic [N_IN-1:0] PAT_LAST  = '1;
  localparam logic [15:0]     MISR_POLY = 16'h1021;
  localparam logic [15:0]     MISR_SEED = 16'hFFFF;

  if (N_IN < 1 || N_IN > 16) begin : g_bad_n_in
    $error("truth_sweep_gen: N_IN must be in 1..16");
  end
  if (N_OUT < 1 || N_OUT > 16) begin : g_bad_n_out
    $error("truth_sweep_gen: N_OUT must be in 1..16");
  end
  if (HOLD < 1) begin : g_bad_hold
    $error("truth_sweep_gen: HOLD must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [HCW-1:0] hold_cnt;
  logic           sample;
  logic           accept;
  logic           last_pat;
  logic [15:0]    misr_nxt;

  assign last_pat = (pattern == PAT_LAST);
  assign misr_nxt = {signature[14:0], 1'b0}
                  ^ (signature[15] ? MISR_POLY : 16'h0000)
                  ^ 16'(dut_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // start is only honoured outside DRIVE, so a mid-sweep start has no effect
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    sample       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        busy = 1'b1;
        if (hold_cnt == HOLD_LAST) begin
          sample = 1'b1;
          if (last_pat) begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_DRIVE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    sample_valid = sample;
  end

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      pattern   <= '0;
      hold_cnt  <= '0;
      signature <= MISR_SEED;
    end else if (state == S_DRIVE) begin
      if (sample) begin
        signature <= misr_nxt;
        hold_cnt  <= '0;
        if (!last_pat) begin
          pattern <= pattern + 1'b1;
        end
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

`ifdef TRUTH_SWEEP_CHECK_EN
  logic [N_OUT-1:0] exp_slice;
  logic             mismatch;

  assign exp_slice = EXPECTED[pattern*N_OUT +: N_OUT];
  assign mismatch  = (dut_out != exp_slice);
  assign fail      = |err_cnt;

  // first_fail latches only while no error has been counted yet
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      err_cnt    <= '0;
      first_fail <= '0;
    end else if (sample && mismatch) begin
      err_cnt <= err_cnt + 1'b1;
      if (err_cnt == '0) begin
        first_fail <= pattern;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/truth_sweep_gen.md
Name: truth_sweep_gen

Overview:
- Parametrised exhaustive-stimulus engine for combinational blocks with N_IN inputs and N_OUT outputs.
- Steps through all 2^N_IN input patterns in ascending binary order, holding each for HOLD cycles, and samples the DUT outputs at the end of each hold window.
- Compresses all samples into a 16-bit MISR signature and flags completion.
- Sits between a bench or top-level controller and the combinational unit under exercise; replaces hand-written per-vector stimulus.

Parameters:
- N_IN, 3, number of DUT inputs; pattern width; legal 1..16.
- N_OUT, 2, number of DUT outputs; legal 1..16.
- HOLD, 5, clock cycles each pattern is held; legal >=1.

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep.
- dut_out  input  N_OUT  DUT outputs sampled by the block.
- pattern  output  N_IN  stimulus driven to DUT inputs.
- busy  output  1  high while a sweep is in progress.
- sample_valid  output  1  one-cycle pulse in the cycle dut_out is captured.
- done  output  1  high after sweep completes, until next start or rst.
- signature  output  16  MISR accumulated over all samples.

Behaviour:
- Reset: rst is synchronous and active-high, sampled on the rising edge of clk. Clock is clk.
- Reset values: pattern=0, busy=0, sample_valid=0, done=0, signature=16'hFFFF. FSM enters IDLE and hold counter clears.
- FSM states:
  - IDLE: start=1 moves to DRIVE on the next edge, with pattern=0, hold_cnt=0, signature=16'hFFFF, done=0, busy=1.
  - DRIVE: hold_cnt increments each cycle. When hold_cnt==HOLD-1, sample_valid=1 in that cycle and dut_out is folded into the MISR at the following edge.
    - If pattern is not all-ones: pattern increments, hold_cnt resets to 0, FSM stays in DRIVE.
    - If pattern is all-ones: FSM goes to DONE.
  - DONE: busy=0, done=1, pattern holds at all-ones, signature holds. start=1 restarts exactly as from IDLE (done clears on the same edge busy rises).
- Latency: the first pattern is visible 1 cycle after start. busy stays high for exactly 2^N_IN*HOLD cycles. done rises on the edge after the last sample.
- MISR update at each sample: sig_next = (sig<<1) ^ (sig[15] ? 16'h1021 : 0) ^ zero_extend(dut_out).
  - If N_OUT>16, this is illegal; assert at elaboration.
- start while busy=1 is ignored, with no restart and no side effects.
- rst mid-sweep aborts immediately to reset values. It has priority over start in the same cycle.
- HOLD=1: every DRIVE cycle is a sample cycle, so sample_valid stays high for the whole sweep.
- pattern wraps never; the all-ones pattern always terminates the sweep.

Optional Feature:
- Macro: TRUTH_SWEEP_CHECK_EN.
- When defined:
  - Adds parameter EXPECTED (N_OUT*2^N_IN bits, default 0). Slice [k*N_OUT +: N_OUT] is the expected output for pattern k.
  - Adds output err_cnt (width N_IN+1): counts samples where dut_out differs from the expected slice.
  - Adds output first_fail (width N_IN): pattern index of the first mismatch, default 0.
  - Adds output fail (1 bit): set if err_cnt is nonzero.
  - All three clear on rst and on accepted start, and hold in DONE.
- When undefined: these ports and logic are absent, and signature behaviour is identical.

Test Plan:
1. N_IN=3, HOLD=5, reset then start pulse -> pattern steps through 0..7, each held 5 cycles. busy high for exactly 40 cycles. 8 sample_valid pulses. done=1 with pattern=3'b111.
2. N_IN=1, N_OUT=2, HOLD=1, dut_out tied 0 -> signature after done = 16'hCF9F (0xFFFF -> 0xEFDF -> 0xCF9F).
3. Same as 2 but dut_out=2'b01 only during pattern 1 -> signature = 16'hCF9E, differing from case 2.
4. Mid-sweep: rst asserted at pattern=3 -> next cycle pattern=0, busy=0, done=0, signature=16'hFFFF. A start pulse during busy is ignored, and sweep length is unchanged.
5. With TRUTH_SWEEP_CHECK_EN, N_IN=3, EXPECTED encoding a 3-input majority, DUT miswired so that only patterns 5 and 6 fail -> err_cnt=2, first_fail=5, fail=1. A restart clears all three.
6. start asserted in DONE -> sweep restarts, done drops on the same edge busy rises, and the new signature is identical to the first run for an unchanged DUT.
